reg_file_scb: RTL and testbench



---
 rtl/reg_file_scb.sv | 134 +++++++++++++
 tb/tb_reg_file_scb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/reg_file_scb.sv
// reg_file_scb: integer register file with an integrated busy-bit scoreboard.
//   clk, rst_n        : clock and synchronous active-low reset
//   rd_addr/rd_data   : NUM_RD combinational read ports, with write->read bypass
//   rd_busy           : per read port, the register is reserved and not being written now
//   wr_en/addr/data   : NUM_WR write ports; the highest port index wins on a collision
//   iss_valid/addr    : destination reservation request; iss_ready accepts it
//   flush             : clears every busy bit; register data is kept
// Register 0 reads as zero, ignores writes and is never reserved.

// One read port: bypass lookup over the write ports, then the stored value.
module reg_file_scb_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WR     = 2
) (
  input  logic [ADDR_WIDTH-1:0]                        rd_addr,
  input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   regs,
  input  logic [(1<<ADDR_WIDTH)-1:0]                   busy,
  input  logic [NUM_WR-1:0]                            wr_en,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]            wr_addr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH-1:0]                        rd_data,
  output logic                                         rd_busy
);
  logic hit;

  always_comb begin
    hit     = 1'b0;
    rd_data = regs[rd_addr];
    // Ascending scan so the highest-index matching write port lands last.
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j] == rd_addr)) begin
        hit     = 1'b1;
        rd_data = wr_data[j];
      end
    end
    if (rd_addr == '0) rd_data = '0;
    // A write in flight resolves the hazard, so the port is not busy.
    rd_busy = busy[rd_addr] && !hit && (rd_addr != '0);
  end
endmodule

module reg_file_scb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic                         iss_ready,
  input  logic                         flush
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic [DEPTH-1:0]                  busy_q, busy_d;

  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wa;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wd;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ra;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_raw;
  logic [NUM_RD-1:0]                 rd_busy_raw;
  logic                              wr_hit_iss;

  assign wa = wr_addr;
  assign wd = wr_data;
  assign ra = rd_addr;

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      reg_file_scb_rdport #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_WR(NUM_WR)
      ) u_rdport (
        .rd_addr (ra[k]),
        .regs    (regs_q),
        .busy    (busy_q),
        .wr_en   (wr_en),
        .wr_addr (wa),
        .wr_data (wd),
        .rd_data (rd_data_raw[k]),
        .rd_busy (rd_busy_raw[k])
      );
    end
  endgenerate

  // Outputs are forced to their idle values while reset is asserted, so the
  // bypass path cannot leak write data during the reset cycle.
  always_comb begin
    wr_hit_iss = 1'b0;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j] && (wa[j] == iss_addr)) wr_hit_iss = 1'b1;
    iss_ready = !rst_n || (iss_addr == '0) || !busy_q[iss_addr] || wr_hit_iss;
    rd_data   = rst_n ? rd_data_raw : '0;
    rd_busy   = rst_n ? rd_busy_raw : '0;
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        if (wa[j] != '0) regs_d[wa[j]] = wd[j];
        busy_d[wa[j]] = 1'b0;
      end
    end
    // Applied after the release so a same-cycle re-issue survives; flush
    // discards the issue and every reservation.
    if (flush)
      busy_d = '0;
    else if (iss_valid && iss_ready && (iss_addr != '0))
      busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_reg_file_scb.sv
module tb_reg_file_scb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        flush;

  always #5 clk = ~clk;

  reg_file_scb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .flush(flush)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iv;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic        er;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic        er;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic rst, logic [1:0] wen, logic [4:0] wa0,
      logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1, logic iv,
      logic [4:0] ia, logic fl, logic [4:0] ra0, logic [4:0] ra1,
      logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, logic er);
    vec_t v;
    v.rst = rst; v.wen = wen; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.er = er;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, check mid-cycle,
  // then let the rising edge commit it.
  task automatic run_vec(input int id, input vec_t v);
    exp_t e, g;
    rst_n = v.rst; wr_en = v.wen;
    wr_addr = {v.wa1, v.wa0}; wr_data = {v.wd1, v.wd0};
    iss_valid = v.iv; iss_addr = v.ia; flush = v.fl;
    rd_addr = {v.ra1, v.ra0};
    e.id = id; e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb; e.er = v.er;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    tests++;
    if (rd_data[31:0] !== g.e0) begin
      fails++; $display("FAIL vec%0d rd_data0 got %h want %h", g.id, rd_data[31:0], g.e0);
    end
    tests++;
    if (rd_data[63:32] !== g.e1) begin
      fails++; $display("FAIL vec%0d rd_data1 got %h want %h", g.id, rd_data[63:32], g.e1);
    end
    tests++;
    if (rd_busy !== g.eb) begin
      fails++; $display("FAIL vec%0d rd_busy got %b want %b", g.id, rd_busy, g.eb);
    end
    tests++;
    if (iss_ready !== g.er) begin
      fails++; $display("FAIL vec%0d iss_ready got %b want %b", g.id, iss_ready, g.er);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                rst wen  wa0 wd0          wa1 wd1    iv ia fl ra0 ra1  e0           e1           eb     er
    tbl.push_back(mk(0, 2'b11, 5, 32'hAA,       6, 32'hBB, 0, 0, 0, 5, 6,  0,           0,           2'b00, 1)); // 0 reset
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 0, 0, 5, 6,  0,           0,           2'b00, 1)); // 1
    tbl.push_back(mk(1, 2'b01, 3, 32'hDEADBEEF, 0, 0,      0, 0, 0, 3, 0,  32'hDEADBEEF, 0,          2'b00, 1)); // 2
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 0, 0, 3, 0,  32'hDEADBEEF, 0,          2'b00, 1)); // 3
    tbl.push_back(mk(1, 2'b11, 0, 32'h1234,     0, 32'h5678,0, 0, 0, 0, 0,  0,           0,           2'b00, 1)); // 4 x0 write
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 0, 0, 0, 3,  0,           32'hDEADBEEF, 2'b00, 1)); // 5
    tbl.push_back(mk(1, 2'b11, 7, 32'h11,       7, 32'h22, 0, 0, 0, 7, 7,  32'h22,      32'h22,      2'b00, 1)); // 6 priority
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 0, 0, 7, 3,  32'h22,      32'hDEADBEEF, 2'b00, 1)); // 7
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      1, 9, 0, 9, 7,  0,           32'h22,      2'b00, 1)); // 8 issue x9
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 9, 0, 9, 7,  0,           32'h22,      2'b01, 0)); // 9
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      1, 9, 0, 9, 7,  0,           32'h22,      2'b01, 0)); // 10 WAW stall
    tbl.push_back(mk(1, 2'b10, 0, 0,            9, 32'h55, 0, 9, 0, 9, 7,  32'h55,      32'h22,      2'b00, 1)); // 11 release
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 9, 0, 9, 7,  32'h55,      32'h22,      2'b00, 1)); // 12
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      1, 9, 0, 9, 7,  32'h55,      32'h22,      2'b00, 1)); // 13 re-issue
    tbl.push_back(mk(1, 2'b01, 9, 32'h66,       0, 0,      1, 9, 0, 9, 7,  32'h66,      32'h22,      2'b00, 1)); // 14 release+issue
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 9, 0, 9, 7,  32'h66,      32'h22,      2'b01, 0)); // 15 still busy
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      1, 1, 0, 1, 2,  0,           0,           2'b00, 1)); // 16 issue x1
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      1, 2, 0, 1, 2,  0,           0,           2'b01, 1)); // 17 issue x2
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      1, 4, 0, 4, 2,  0,           0,           2'b10, 1)); // 18 issue x4
    tbl.push_back(mk(1, 2'b01, 3, 32'h77,       0, 0,      1, 8, 1, 4, 1,  0,           0,           2'b11, 1)); // 19 flush
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 8, 0, 8, 9,  0,           32'h66,      2'b00, 1)); // 20
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 4, 0, 3, 7,  32'h77,      32'h22,      2'b00, 1)); // 21
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      1, 0, 0, 1, 2,  0,           0,           2'b00, 1)); // 22 issue x0
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 1, 0, 0, 4,  0,           0,           2'b00, 1)); // 23
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      1, 5, 0, 3, 5,  32'h77,      0,           2'b00, 1)); // 24 issue x5
    tbl.push_back(mk(0, 2'b01, 3, 32'h99,       0, 0,      1, 6, 0, 5, 3,  0,           0,           2'b00, 1)); // 25 reset again
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 6, 0, 5, 3,  0,           0,           2'b00, 1)); // 26
    tbl.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 5, 0, 6, 9,  0,           0,           2'b00, 1)); // 27

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Hand sequence: two ports writing different registers, one reserved,
    // then a flush racing a write to the reserved register.
    run_vec(100, mk(1, 2'b00, 0, 0,        0,  0,        1, 10, 0, 10, 11, 0,        0,        2'b00, 1));
    run_vec(101, mk(1, 2'b11, 11, 32'hA5,  12, 32'h5A,   0, 10, 0, 10, 12, 0,        32'h5A,   2'b01, 0));
    run_vec(102, mk(1, 2'b10, 0, 0,        10, 32'hC3,   0, 10, 1, 11, 10, 32'hA5,   32'hC3,   2'b00, 1));
    run_vec(103, mk(1, 2'b00, 0, 0,        0,  0,        0, 10, 0, 10, 12, 32'hC3,   32'h5A,   2'b00, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
